addsub_serial_32: RTL and testbench
===================================

ADDSUB_SERIAL_32 -- requirements
Module: addsub_serial_32

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, bits processed per compute cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operands valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a, input, 32, signed two's-complement operand A.
REQ-007 SHALL have port b, input, 32, signed two's-complement operand B.
REQ-008 SHALL have port sub, input, 1, operation select: 0 gives a+b, 1 gives a-b.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port result, output, 32, sum or difference modulo 2^32.
REQ-012 SHALL have port cout, output, 1, carry out of bit 31 (for subtraction, 1 means no borrow).
REQ-013 SHALL have port overflow, output, 1, signed overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, COMPUTE and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and in_ready=0 in COMPUTE and DONE.
REQ-016 SHALL, on a clock edge where in_valid && in_ready, capture the operands and move IDLE->COMPUTE.
  - Captured values: a, b XOR {32{sub}}, and carry register = sub.
  - The digit counter SHALL be cleared on capture.
REQ-017 SHALL, in each COMPUTE cycle, add one DIGIT_W-bit digit, LSB digit first, using the carry register as carry-in.
  - The digit sum SHALL be written into result, and the digit carry-out SHALL be stored.
REQ-018 SHALL spend exactly 32/DIGIT_W COMPUTE cycles, then move COMPUTE->DONE.
  - For DIGIT_W=4, out_valid SHALL rise 8 edges after the capture edge.
REQ-019 SHALL, on the last digit, set cout = carry out of bit 31 and overflow = carry into bit 31 XOR carry out of bit 31.
REQ-020 SHALL drive out_valid=1 only in DONE.
REQ-021 SHALL hold result, cout and overflow stable while out_valid && !out_ready, for any number of cycles.
REQ-022 SHALL, on a clock edge where out_valid && out_ready, move DONE->IDLE; in_ready SHALL be 1 in the next cycle.
REQ-023 SHALL keep result, cout and overflow at their last values in IDLE until the next capture.
REQ-024 SHALL ignore a, b, sub and in_valid outside IDLE.
REQ-025 SHALL produce a+b for sub=0 and a-b for sub=1, including for the operand 0x80000000.

Reset
REQ-026 SHALL, when rst_n=0 at a rising clk edge, enter IDLE from any state and clear all outputs.
  - Values after reset: in_ready=1, out_valid=0, result=0, cout=0, overflow=0.
  - The carry register and digit counter SHALL be cleared.
REQ-027 SHALL abort any computation in progress on reset mid-operation; no partial result SHALL ever assert out_valid.

Structure
REQ-028 SHALL take the following from shared package addsub_pkg:
  - DATA_W=32
  - the state enum (IDLE, COMPUTE, DONE)
  - the op encoding (OP_ADD=0, OP_SUB=1)
REQ-029 SHALL instantiate one combinational sub-module, addsub_digit.
  - Inputs: DIGIT_W-bit x, y, cin.
  - Outputs: s, cout, and c_msb (carry into the digit MSB, used for overflow).

Verification
REQ-030 SHALL be verified with add 0x5FFFE8CA + 0x54F4FFFF, sub=0 -> result=0xB4F4E8C9, cout=0, overflow=1, out_valid 8 edges after capture.
REQ-031 SHALL be verified with add 0xA0A0FFFF + 0xA0BFFFE0 -> result=0x4160FFDF, cout=1, overflow=1.
REQ-032 SHALL be verified with sub 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, cout=1, overflow=1; and sub 0x00000000 - 0x00000001 -> result=0xFFFFFFFF, cout=0, overflow=0.
REQ-033 SHALL be verified with back-pressure: out_ready=0 for 5 cycles in DONE -> result, cout and overflow constant and in_ready=0; then out_ready=1 -> in_ready=1 the next cycle.
REQ-034 SHALL be verified with rst_n=0 at the 3rd COMPUTE cycle -> the next cycle shows in_ready=1, out_valid=0, result=0; the next transaction computes correctly.
REQ-035 SHALL be verified with back-to-back transactions (in_valid held high, out_ready held high) -> each result correct and no operand lost or duplicated.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and encodings for the digit-serial adder/subtractor.
package addsub_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT_W-bit ripple slice: sum, carry out, and carry into the slice MSB.
module addsub_digit #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               c_msb
);

  localparam int unsigned SUM_W = DIGIT_W + 1;

  logic [DIGIT_W:0] sum_c;

  // Widened add; the MSB carry-in is recovered from the MSB sum bit.
  always_comb begin
    sum_c = {1'b0, x} + {1'b0, y} + SUM_W'(cin);
    s     = sum_c[DIGIT_W-1:0];
    cout  = sum_c[DIGIT_W];
    c_msb = sum_c[DIGIT_W-1] ^ x[DIGIT_W-1] ^ y[DIGIT_W-1];
  end

endmodule

// File: rtl/addsub_serial_32.sv
// 32-bit add/subtract processed one DIGIT_W-bit digit per cycle, LSB digit first,
// with valid/ready handshakes on both sides.
module addsub_serial_32
  import addsub_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              overflow
);

  localparam int unsigned NUM_DIGITS = DATA_W / DIGIT_W;
  localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIGIT_SH   = $clog2(DIGIT_W);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, b_q, result_q;
  logic                carry_q, cout_q, ovf_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                in_ready_q, out_valid_q;

  logic                load_c, step_c, last_c;
  logic [4:0]          base_c;
  logic [DIGIT_W-1:0]  x_c, y_c, s_c;
  logic                dcout_c, dmsb_c;

  // State register; handshake flags track the next state so they are flop outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)               state_d = COMPUTE;
      COMPUTE: if (cnt_q == LAST_DIGIT)    state_d = DONE;
      DONE:    if (out_ready)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    last_c = 1'b0;
    if (state_q == IDLE) begin
      load_c = in_valid;
    end
    if (state_q == COMPUTE) begin
      step_c = 1'b1;
      last_c = (cnt_q == LAST_DIGIT);
    end
  end

  // Select the current digit of both operands.
  always_comb begin
    base_c = 5'(32'(cnt_q) << DIGIT_SH);
    x_c    = a_q[base_c +: DIGIT_W];
    y_c    = b_q[base_c +: DIGIT_W];
  end

  addsub_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .x     (x_c),
    .y     (y_c),
    .cin   (carry_q),
    .s     (s_c),
    .cout  (dcout_c),
    .c_msb (dmsb_c)
  );

  // Operand capture, per-digit accumulation and final flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load_c) begin
      a_q     <= a;
      b_q     <= b ^ {DATA_W{sub}};
      carry_q <= (op_e'(sub) == OP_SUB);
      cnt_q   <= '0;
    end else if (step_c) begin
      result_q[base_c +: DIGIT_W] <= s_c;
      carry_q <= dcout_c;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_c) begin
        cout_q <= dcout_c;
        ovf_q  <= dmsb_c ^ dcout_c;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_addsub_serial_32.sv
// Scoreboard bench for addsub_serial_32: expected results are queued at capture
// and checked by an independent output monitor.
module tb_addsub_serial_32;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NDIG    = 32 / DIGIT_W;
  localparam int unsigned PERIOD  = 10;
  localparam time         LAT     = NDIG * PERIOD + PERIOD / 2;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
    time         t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        cout;
  logic        overflow;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   n_sent = 0;
  int   n_done = 0;
  int   mode   = 1;
  bit   hs_prev = 1'b0;
  bit   ov_prev = 1'b0;

  addsub_serial_32 #(.DIGIT_W(DIGIT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #(PERIOD / 2) clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic and sign rules.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t        e;
    logic [32:0] w;
    if (!s) begin
      w   = {1'b0, x} + {1'b0, y};
      e.r = w[31:0];
      e.c = w[32];
      e.o = (x[31] == y[31]) && (e.r[31] != x[31]);
    end else begin
      e.r = x - y;
      e.c = (x >= y);
      e.o = (x[31] != y[31]) && (e.r[31] != x[31]);
    end
    e.t = 0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Result sink: random, always-ready, or held-off back-pressure.
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitor: compares every presented result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (hs_prev) begin
        chk("in_ready_after_accept", 32'(in_ready), 32'd1);
        chk("out_valid_after_accept", 32'(out_valid), 32'd0);
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q[0];
          if (!ov_prev) chk("latency", 32'($time - e.t), 32'(LAT));
          chk("result", result, e.r);
          chk("cout", 32'(cout), 32'(e.c));
          chk("overflow", 32'(overflow), 32'(e.o));
          chk("in_ready_in_done", 32'(in_ready), 32'd0);
          if (out_ready === 1'b1) begin
            void'(q.pop_front());
            n_done++;
          end
        end
      end
    end
    hs_prev = (rst_n === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b1);
    ov_prev = (rst_n === 1'b1) && (out_valid === 1'b1);
  end

  // Present operands until accepted, then queue the expected response.
  task automatic send(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                      input bit keep, input bit use_exp,
                      input logic [31:0] er, input logic ec, input logic eo);
    exp_t e;
    int   n;
    bit   got;
    in_valid = 1'b1;
    a        = ta;
    b        = tbv;
    sub      = ts;
    n        = 0;
    got      = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      got = (in_ready === 1'b1) && (rst_n === 1'b1);
    end
    chk("capture_timeout", 32'(got), 32'd1);
    if (got) begin
      if (use_exp) begin
        e.r = er;
        e.c = ec;
        e.o = eo;
      end else begin
        e = model(ta, tbv, ts);
      end
      e.t = $time;
      q.push_back(e);
      n_sent++;
    end
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      sub      = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_rand(input bit keep);
    send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), keep, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    sub      = 1'b0;
    mode     = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known vectors, including the 0x80000000 corner.
    send(32'h5FFF_E8CA, 32'h54F4_FFFF, 1'b0, 1'b0, 1'b1, 32'hB4F4_E8C9, 1'b0, 1'b1);
    drain();
    send(32'hA0A0_FFFF, 32'hA0BF_FFE0, 1'b0, 1'b0, 1'b1, 32'h4160_FFDF, 1'b1, 1'b1);
    drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    drain();
    send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();

    // Back-pressure: hold the result off for five cycles, then release.
    mode = 2;
    @(posedge clk);
    #1;
    send_rand(1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    mode = 1;
    drain();

    // Reset during the third compute cycle aborts the operation.
    send_rand(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    n_sent--;
    @(negedge clk);
    check_reset_state("abort");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_rand(1'b0);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 10; i++) send_rand(1'b1);
    in_valid = 1'b0;
    drain();

    // Random traffic with random gaps and random consumer stalls.
    mode = 0;
    for (int i = 0; i < 40; i++) begin
      send_rand($urandom_range(0, 1) == 1);
      if (!in_valid) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    mode     = 1;
    drain();

    chk("completed_count", 32'(n_done), 32'(n_sent));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
